// File: rtl/robot_pkg.sv
// Shared types and constants for the robot motion scheduler and its grant arbiter.
package robot_pkg;

  typedef enum logic [1:0] {
    CMD_STOP = 2'b00,
    CMD_FWD  = 2'b01,
    CMD_TURN = 2'b10,
    CMD_RSVD = 2'b11
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_FWD  = 2'b01,
    ST_TURN = 2'b10,
    ST_GAP  = 2'b11
  } sched_state_t;

  localparam logic OWNER_AUTO   = 1'b0;
  localparam logic OWNER_REMOTE = 1'b1;

  // One-hot grant encoding: bit 0 is auto, bit 1 is remote.
  localparam logic [1:0] GNT_AUTO   = 2'b01;
  localparam logic [1:0] GNT_REMOTE = 2'b10;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/robot_grant_arbiter.sv
// Fixed-priority grant between remote and auto sources, with a burst limit that
// lets a waiting auto request through after REMOTE_BURST consecutive remote grants.
module robot_grant_arbiter
  import robot_pkg::*;
#(
  parameter int REMOTE_BURST = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       auto_valid,
  input  logic       remote_valid,
  input  logic       accept,
  output logic [1:0] grant
);

  localparam int BURST_W = $clog2(REMOTE_BURST + 1);

  logic [BURST_W-1:0] consec_remote;
  logic               burst_full;

  assign burst_full = (consec_remote == BURST_W'(REMOTE_BURST));

  // Grant selection; a lone auto request must still be served, so auto wins
  // whenever remote is idle or the remote burst budget is spent.
  always_comb begin
    grant = GNT_REMOTE;
    if (auto_valid && (!remote_valid || burst_full)) begin
      grant = GNT_AUTO;
    end else begin
      grant = GNT_REMOTE;
    end
  end

  // Saturating count of remote grants taken while auto was waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      consec_remote <= {BURST_W{1'b0}};
    end else if (accept) begin
      if (grant == GNT_AUTO) begin
        consec_remote <= {BURST_W{1'b0}};
      end else if (auto_valid && !burst_full) begin
        consec_remote <= consec_remote + BURST_W'(1);
      end else begin
        consec_remote <= consec_remote;
      end
    end else begin
      consec_remote <= consec_remote;
    end
  end

endmodule

// File: rtl/robot_motion_scheduler.sv
// Expands accepted STOP/FWD/TURN commands into timed front/turn pulses, aborts
// forward moves on obstacles, and inserts one dead cycle between commands.
module robot_motion_scheduler
  import robot_pkg::*;
#(
  parameter int FWD_CYCLES   = 4,
  parameter int TURN_CYCLES  = 2,
  parameter int REMOTE_BURST = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       front_sensor,
  input  logic       left_sensor,
  input  logic       auto_valid,
  input  logic [1:0] auto_cmd,
  output logic       auto_ready,
  input  logic       remote_valid,
  input  logic [1:0] remote_cmd,
  output logic       remote_ready,
  output logic       front,
  output logic       turn,
  output logic       abort,
  output logic       owner,
  output logic [1:0] status
);

  localparam int MAX_CYCLES = max_int(FWD_CYCLES, TURN_CYCLES);
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  sched_state_t     state;
  sched_state_t     state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             abort_next;
  logic             owner_next;
  logic [1:0]       grant;
  logic             idle;
  logic             accept;
  logic             sel_remote;
  cmd_t             sel_cmd;

  robot_grant_arbiter #(
    .REMOTE_BURST (REMOTE_BURST)
  ) u_arbiter (
    .clk          (clk),
    .reset        (reset),
    .auto_valid   (auto_valid),
    .remote_valid (remote_valid),
    .accept       (accept),
    .grant        (grant)
  );

  // Handshake: ready only in IDLE, steered by the arbiter's grant.
  always_comb begin
    idle         = (state == ST_IDLE);
    auto_ready   = idle & grant[0];
    remote_ready = idle & grant[1];
    accept       = (auto_ready & auto_valid) | (remote_ready & remote_valid);
    sel_remote   = grant[1];
    if (sel_remote) begin
      sel_cmd = cmd_t'(remote_cmd);
    end else begin
      sel_cmd = cmd_t'(auto_cmd);
    end
  end

  // Next-state, duration counter, abort pulse and owner selection.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    abort_next = 1'b0;
    owner_next = owner;
    case (state)
      ST_IDLE: begin
        cnt_next = {CNT_W{1'b0}};
        if (accept) begin
          owner_next = sel_remote ? OWNER_REMOTE : OWNER_AUTO;
          case (sel_cmd)
            CMD_FWD: begin
              if (front_sensor) begin
                state_next = ST_GAP;
                abort_next = 1'b1;
              end else begin
                state_next = ST_FWD;
                cnt_next   = CNT_W'(FWD_CYCLES);
              end
            end
            CMD_TURN: begin
              state_next = ST_TURN;
              cnt_next   = CNT_W'(TURN_CYCLES);
            end
            default: begin
              state_next = ST_GAP;
            end
          endcase
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_FWD: begin
        if (front_sensor) begin
          state_next = ST_GAP;
          cnt_next   = {CNT_W{1'b0}};
          abort_next = 1'b1;
        end else if (cnt == CNT_W'(1)) begin
          state_next = ST_GAP;
          cnt_next   = {CNT_W{1'b0}};
        end else begin
          state_next = ST_FWD;
          cnt_next   = cnt - CNT_W'(1);
        end
      end
      ST_TURN: begin
        if (cnt == CNT_W'(1)) begin
          state_next = ST_GAP;
          cnt_next   = {CNT_W{1'b0}};
        end else begin
          state_next = ST_TURN;
          cnt_next   = cnt - CNT_W'(1);
        end
      end
      ST_GAP: begin
        state_next = ST_IDLE;
        cnt_next   = {CNT_W{1'b0}};
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and registered outputs; actuators follow the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= {CNT_W{1'b0}};
      front  <= 1'b0;
      turn   <= 1'b0;
      abort  <= 1'b0;
      owner  <= OWNER_AUTO;
      status <= 2'b00;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      front  <= (state_next == ST_FWD);
      turn   <= (state_next == ST_TURN);
      abort  <= abort_next;
      owner  <= owner_next;
      status <= {front_sensor, left_sensor};
    end
  end

endmodule

// File: tb/tb_robot_motion_scheduler.sv
// Randomized bench for robot_motion_scheduler, checked against a schedule-queue
// model of the actuator timeline and the remote-burst grant rule.
module tb_robot_motion_scheduler;

  localparam int FWD_CYCLES   = 4;
  localparam int TURN_CYCLES  = 2;
  localparam int REMOTE_BURST = 3;
  localparam int N_CYCLES     = 1600;

  logic       clk = 1'b0;
  logic       reset;
  logic       front_sensor;
  logic       left_sensor;
  logic       auto_valid;
  logic [1:0] auto_cmd;
  logic       auto_ready;
  logic       remote_valid;
  logic [1:0] remote_cmd;
  logic       remote_ready;
  logic       front;
  logic       turn;
  logic       abort;
  logic       owner;
  logic [1:0] status;

  always #5 clk = ~clk;

  robot_motion_scheduler #(
    .FWD_CYCLES   (FWD_CYCLES),
    .TURN_CYCLES  (TURN_CYCLES),
    .REMOTE_BURST (REMOTE_BURST)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .front_sensor (front_sensor),
    .left_sensor  (left_sensor),
    .auto_valid   (auto_valid),
    .auto_cmd     (auto_cmd),
    .auto_ready   (auto_ready),
    .remote_valid (remote_valid),
    .remote_cmd   (remote_cmd),
    .remote_ready (remote_ready),
    .front        (front),
    .turn         (turn),
    .abort        (abort),
    .owner        (owner),
    .status       (status)
  );

  // Model: the current cycle's activity plus a queue of planned future cycles.
  typedef enum int {P_IDLE, P_FWD, P_TURN, P_GAP} phase_t;

  phase_t     cur = P_IDLE;
  phase_t     plan[$];
  int         consec = 0;
  logic       m_owner = 1'b0;
  logic       m_abort = 1'b0;
  logic [1:0] m_status = 2'b00;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic auto_wins();
    return auto_valid && (!remote_valid || consec == REMOTE_BURST);
  endfunction

  task automatic start_cmd(input logic [1:0] cmd);
    if (cmd == 2'b01) begin
      if (front_sensor) begin
        cur     = P_GAP;
        m_abort = 1'b1;
      end else begin
        cur = P_FWD;
        for (int i = 1; i < FWD_CYCLES; i++) plan.push_back(P_FWD);
        plan.push_back(P_GAP);
      end
    end else if (cmd == 2'b10) begin
      cur = P_TURN;
      for (int i = 1; i < TURN_CYCLES; i++) plan.push_back(P_TURN);
      plan.push_back(P_GAP);
    end else begin
      cur = P_GAP;
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    m_abort = 1'b0;
    if (reset) begin
      plan.delete();
      cur      = P_IDLE;
      m_owner  = 1'b0;
      consec   = 0;
      m_status = 2'b00;
    end else begin
      m_status = {front_sensor, left_sensor};
      if (cur == P_FWD && front_sensor) begin
        plan.delete();
        cur     = P_GAP;
        m_abort = 1'b1;
      end else if (cur == P_IDLE) begin
        if (auto_wins() && auto_valid) begin
          m_owner = 1'b0;
          consec  = 0;
          start_cmd(auto_cmd);
        end else if (!auto_wins() && remote_valid) begin
          m_owner = 1'b1;
          if (auto_valid && consec < REMOTE_BURST) consec++;
          start_cmd(remote_cmd);
        end
      end else if (plan.size() > 0) begin
        cur = plan.pop_front();
      end else begin
        cur = P_IDLE;
      end
    end
  end

  initial begin
    int mode;
    reset        = 1'b1;
    front_sensor = 1'b0;
    left_sensor  = 1'b0;
    auto_valid   = 1'b0;
    auto_cmd     = 2'b00;
    remote_valid = 1'b0;
    remote_cmd   = 2'b00;
    repeat (2) @(posedge clk);
    for (int i = 0; i < N_CYCLES; i++) begin
      @(negedge clk);
      check_eq("front",  front,  cur == P_FWD);
      check_eq("turn",   turn,   cur == P_TURN);
      check_eq("abort",  abort,  m_abort);
      check_eq("owner",  owner,  m_owner);
      check_eq("status", status, m_status);

      mode = (i / 200) % 4;
      case (mode)
        0: begin
          // Both sources hammering TURN: exercises the burst limit.
          reset        = 1'b0;
          auto_valid   = 1'b1;
          remote_valid = 1'b1;
          auto_cmd     = 2'b10;
          remote_cmd   = 2'b10;
          front_sensor = 1'b0;
          left_sensor  = 1'($urandom_range(0, 1));
        end
        1: begin
          reset        = ($urandom_range(0, 63) == 0);
          auto_valid   = 1'($urandom_range(0, 1));
          remote_valid = ($urandom_range(0, 3) == 0);
          auto_cmd     = 2'($urandom_range(0, 3));
          remote_cmd   = 2'($urandom_range(0, 3));
          front_sensor = ($urandom_range(0, 9) == 0);
          left_sensor  = 1'($urandom_range(0, 1));
        end
        2: begin
          // Mostly FWD with frequent obstacles.
          reset        = ($urandom_range(0, 99) == 0);
          auto_valid   = ($urandom_range(0, 3) != 0);
          remote_valid = 1'($urandom_range(0, 1));
          auto_cmd     = ($urandom_range(0, 3) != 0) ? 2'b01 : 2'($urandom_range(0, 3));
          remote_cmd   = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'($urandom_range(0, 3));
          front_sensor = ($urandom_range(0, 9) < 3);
          left_sensor  = 1'($urandom_range(0, 1));
        end
        default: begin
          // Held remote request with frequent resets mid-command.
          reset        = ($urandom_range(0, 7) == 0);
          auto_valid   = 1'($urandom_range(0, 1));
          remote_valid = 1'b1;
          auto_cmd     = 2'($urandom_range(0, 3));
          remote_cmd   = 2'($urandom_range(1, 2));
          front_sensor = ($urandom_range(0, 15) == 0);
          left_sensor  = 1'($urandom_range(0, 1));
        end
      endcase

      #1;
      check_eq("auto_ready",   auto_ready,   (cur == P_IDLE) && auto_wins());
      check_eq("remote_ready", remote_ready, (cur == P_IDLE) && !auto_wins());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
